spam_cpu_core: RTL and testbench

- Single-cycle 8-bit Harvard CPU: 16-bit program counter, 48-bit instruction words from an internal program ROM, 8-bit ALU, four general registers, memory address register pair, 64K x 8 data RAM.
- Top-level processor; only clock and reset are ports. Verification observes state hierarchically via the signals named below.
- Port declaration order is reset then clk, so positional instantiation (reset, clk) works.

---
 rtl/spam_cpu_core.sv | 219 +++++++++++++++++++++
 tb/tb_spam_cpu_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spam_cpu_core.sv
// rtl/spam_cpu_core.sv - single-cycle 8-bit Harvard CPU with 48-bit instruction ROM and 64K x 8 data RAM
// The ROM image (ROM_FILE) is placed into rom[] by the build or simulation
// environment; the core only ever reads it.
module spam_cpu_core #(
  parameter string ROM_FILE  = "program.hex",
  parameter int    ROM_DEPTH = 65536
) (
  input logic reset,
  input logic clk
);

  logic [47:0] rom [ROM_DEPTH];
  logic [7:0]  ram [65536];

  logic [15:0] pc_q, pc_d;
  logic [7:0]  reg_a_q, reg_a_d, reg_b_q, reg_b_d, reg_c_q, reg_c_d, reg_d_q, reg_d_d;
  logic [7:0]  marlo_q, marlo_d, marhi_q, marhi_d;
  logic        z_q, z_d, c_q, c_d, o_q, o_d, n_q, n_d;

  // Architectural names used when observing the core from outside
  logic [15:0] pc;
  logic [7:0]  reg_a, reg_b, reg_c, reg_d, marlo, marhi;
  logic        z, c, o, n;
  assign pc = pc_q;
  assign reg_a = reg_a_q;
  assign reg_b = reg_b_q;
  assign reg_c = reg_c_q;
  assign reg_d = reg_d_q;
  assign marlo = marlo_q;
  assign marhi = marhi_q;
  assign z = z_q;
  assign c = c_q;
  assign o = o_q;
  assign n = n_q;

  logic [47:0] instr;
  logic [3:0]  aluop, target;
  logic [2:0]  srca, srcb, cond;
  logic        setflags;
  logic [15:0] address;
  logic [7:0]  immed;
  logic [15:0] mar;
  logic [7:0]  ram_rd;

  // Addresses past the populated ROM read as an all-zero word
  assign instr    = (32'(pc) < ROM_DEPTH) ? rom[pc] : 48'h0;
  assign aluop    = instr[47:44];
  assign target   = instr[43:40];
  assign srca     = instr[39:37];
  assign srcb     = instr[36:34];
  assign cond     = instr[33:31];
  assign setflags = instr[30];
  assign address  = instr[23:8];
  assign immed    = instr[7:0];
  assign mar      = {marhi, marlo};
  assign ram_rd   = ram[mar];

  logic [7:0] op_a, op_b;

  // Operand multiplexers for the two ALU inputs
  always_comb begin
    op_a = 8'h00;
    op_b = 8'h00;
    case (srca)
      3'd0: op_a = reg_a;
      3'd1: op_a = reg_b;
      3'd2: op_a = reg_c;
      3'd3: op_a = reg_d;
      3'd4: op_a = marlo;
      3'd5: op_a = marhi;
      3'd6: op_a = ram_rd;
      default: op_a = immed;
    endcase
    case (srcb)
      3'd0: op_b = reg_a;
      3'd1: op_b = reg_b;
      3'd2: op_b = reg_c;
      3'd3: op_b = reg_d;
      3'd4: op_b = marlo;
      3'd5: op_b = marhi;
      3'd6: op_b = ram_rd;
      default: op_b = immed;
    endcase
  end

  logic [7:0] ax, ay;
  logic       acin;
  logic [8:0] sum9, dif9;
  logic [7:0] result;
  logic       c_res, o_res;

  assign sum9 = {1'b0, ax} + {1'b0, ay} + {8'h00, acin};
  assign dif9 = {1'b0, ax} - {1'b0, ay} - {8'h00, acin};

  // ALU: shared adder/subtractor feeds the arithmetic ops, C is carry or borrow
  always_comb begin
    ax     = op_a;
    ay     = op_b;
    acin   = 1'b0;
    result = 8'h00;
    c_res  = 1'b0;
    o_res  = 1'b0;
    case (aluop)
      4'd5:  begin ax = op_b; ay = op_a; end
      4'd6,
      4'd7:  acin = c;
      4'd14,
      4'd15: ay = 8'h01;
      default: ;
    endcase
    case (aluop)
      4'd1:  result = op_a;
      4'd2:  result = op_b;
      4'd3, 4'd6, 4'd14: begin
        result = sum9[7:0];
        c_res  = sum9[8];
        o_res  = (ax[7] == ay[7]) && (sum9[7] != ax[7]);
      end
      4'd4, 4'd5, 4'd7, 4'd15: begin
        result = dif9[7:0];
        c_res  = dif9[8];
        o_res  = (ax[7] != ay[7]) && (dif9[7] != ax[7]);
      end
      4'd8:  result = op_a & op_b;
      4'd9:  result = op_a | op_b;
      4'd10: result = op_a ^ op_b;
      4'd11: result = ~op_a;
      4'd12: begin result = {op_a[6:0], 1'b0}; c_res = op_a[7]; end
      4'd13: begin result = {1'b0, op_a[7:1]}; c_res = op_a[0]; end
      default: result = 8'h00;
    endcase
  end

  logic take, jump, ram_we;

  // Condition check on the incoming flags, then gated register/flag/pc updates
  always_comb begin
    pc_d    = pc_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    reg_c_d = reg_c_q;
    reg_d_d = reg_d_q;
    marlo_d = marlo_q;
    marhi_d = marhi_q;
    z_d     = z_q;
    c_d     = c_q;
    o_d     = o_q;
    n_d     = n_q;
    jump    = 1'b0;
    ram_we  = 1'b0;
    case (cond)
      3'd0: take = 1'b1;
      3'd1: take = z;
      3'd2: take = !z;
      3'd3: take = c;
      3'd4: take = !c;
      3'd5: take = o;
      3'd6: take = n;
      default: take = 1'b0;
    endcase
    if (take) begin
      if (setflags) begin
        z_d = (result == 8'h00);
        n_d = result[7];
        c_d = c_res;
        o_d = o_res;
      end
      case (target)
        4'd0: reg_a_d = result;
        4'd1: reg_b_d = result;
        4'd2: reg_c_d = result;
        4'd3: reg_d_d = result;
        4'd4: marlo_d = result;
        4'd5: marhi_d = result;
        4'd6: ram_we  = 1'b1;
        4'd7: jump    = 1'b1;
        default: ;
      endcase
    end
    pc_d = jump ? address : pc_q + 16'd1;
  end

  // Architectural state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= 16'h0000;
      reg_a_q <= 8'h00;
      reg_b_q <= 8'h00;
      reg_c_q <= 8'h00;
      reg_d_q <= 8'h00;
      marlo_q <= 8'h00;
      marhi_q <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      o_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      reg_c_q <= reg_c_d;
      reg_d_q <= reg_d_d;
      marlo_q <= marlo_d;
      marhi_q <= marhi_d;
      z_q     <= z_d;
      c_q     <= c_d;
      o_q     <= o_d;
      n_q     <= n_d;
    end
  end

  // Data RAM write port; reset suppresses the write and never clears contents
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram[mar] <= result;
    end
  end

endmodule

// File: tb/tb_spam_cpu_core.sv
// tb/tb_spam_cpu_core.sv - directed self-checking bench for spam_cpu_core
module tb_spam_cpu_core;

  logic reset;
  logic clk;
  int   n_cmp;
  int   n_bad;

  spam_cpu_core dut (
    .reset(reset),
    .clk  (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;   // {z, c, o, n}
  } vec_t;

  vec_t vecs [19];

  function automatic logic [47:0] enc(input int op, input int tgt, input int sa, input int sb,
                                      input int cnd, input int sf, input int addr, input int imm);
    return {op[3:0], tgt[3:0], sa[2:0], sb[2:0], cnd[2:0], sf[0], 6'b0, addr[15:0], imm[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) dut.rom[i] = 48'h0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_flags(input string name, input logic [3:0] exp);
    check(name, {28'h0, dut.z, dut.c, dut.o, dut.n}, {28'h0, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;

    vecs[0]  = '{"add_ff_01",   4'd3,  1'b0, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vecs[1]  = '{"add_ovf",     4'd3,  1'b0, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[2]  = '{"sub_borrow",  4'd4,  1'b0, 8'h00, 8'h01, 8'hFF, 4'b0101};
    vecs[3]  = '{"sub_ovf",     4'd4,  1'b0, 8'h80, 8'h01, 8'h7F, 4'b0010};
    vecs[4]  = '{"rsub",        4'd5,  1'b0, 8'h05, 8'h03, 8'hFE, 4'b0101};
    vecs[5]  = '{"adc_c1",      4'd6,  1'b1, 8'h10, 8'h20, 8'h31, 4'b0000};
    vecs[6]  = '{"adc_c0",      4'd6,  1'b0, 8'h10, 8'h20, 8'h30, 4'b0000};
    vecs[7]  = '{"sbc_c1",      4'd7,  1'b1, 8'h10, 8'h10, 8'hFF, 4'b0101};
    vecs[8]  = '{"and",         4'd8,  1'b1, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[9]  = '{"or",          4'd9,  1'b1, 8'hF0, 8'h0F, 8'hFF, 4'b0001};
    vecs[10] = '{"xor",         4'd10, 1'b0, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    vecs[11] = '{"not",         4'd11, 1'b0, 8'h0F, 8'h00, 8'hF0, 4'b0001};
    vecs[12] = '{"shl",         4'd12, 1'b0, 8'h81, 8'h00, 8'h02, 4'b0100};
    vecs[13] = '{"shr",         4'd13, 1'b0, 8'h81, 8'h00, 8'h40, 4'b0100};
    vecs[14] = '{"inc_ovf",     4'd14, 1'b0, 8'h7F, 8'h00, 8'h80, 4'b0011};
    vecs[15] = '{"dec_borrow",  4'd15, 1'b0, 8'h00, 8'h00, 8'hFF, 4'b0101};
    vecs[16] = '{"zero",        4'd0,  1'b1, 8'h55, 8'h66, 8'h00, 4'b1000};
    vecs[17] = '{"pass_b",      4'd2,  1'b0, 8'h11, 8'h9C, 8'h9C, 4'b0001};
    vecs[18] = '{"inc_wrap",    4'd14, 1'b0, 8'hFF, 8'h00, 8'h00, 4'b1100};

    // Reset state
    clear_rom();
    apply_reset();
    check("rst_pc", {16'h0, dut.pc}, 32'h0);
    check("rst_a", {24'h0, dut.reg_a}, 32'h0);
    check("rst_mar", {16'h0, dut.marhi, dut.marlo}, 32'h0);
    check_flags("rst_flags", 4'b0000);

    // Free run through zero words
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("freerun_pc", {16'h0, dut.pc}, i);
    end
    check("freerun_a", {24'h0, dut.reg_a}, 32'h0);

    // ALU table: preset C, load A and B, execute op with setflags
    foreach (vecs[k]) begin
      clear_rom();
      dut.rom[0] = enc(12, 3, 7, 0, 0, 1, 0, {24'h0, vecs[k].cin, 7'b0});
      dut.rom[1] = enc(1, 0, 7, 0, 0, 0, 0, {24'h0, vecs[k].a});
      dut.rom[2] = enc(1, 1, 7, 0, 0, 0, 0, {24'h0, vecs[k].b});
      dut.rom[3] = enc({28'h0, vecs[k].op}, 0, 0, 1, 0, 1, 0, 0);
      apply_reset();
      repeat (4) tick();
      check({vecs[k].name, "_res"}, {24'h0, dut.reg_a}, {24'h0, vecs[k].res});
      check_flags({vecs[k].name, "_flags"}, vecs[k].flg);
      check({vecs[k].name, "_b"}, {24'h0, dut.reg_b}, {24'h0, vecs[k].b});
    end

    // Jump chain
    clear_rom();
    dut.rom[0]     = enc(0, 7, 0, 0, 0, 0, 256, 0);
    dut.rom[256]   = enc(0, 7, 0, 0, 0, 0, 32768, 0);
    dut.rom[32768] = enc(0, 7, 0, 0, 0, 0, 65520, 0);
    dut.rom[65520] = enc(0, 7, 0, 0, 0, 0, 0, 0);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] chain [4];
      chain[0] = 16'd256;
      chain[1] = 16'd32768;
      chain[2] = 16'd65520;
      chain[3] = 16'd0;
      tick();
      check("jmp_chain_pc", {16'h0, dut.pc}, {16'h0, chain[i % 4]});
    end

    // Reset mid-run aborts the RAM write in flight
    clear_rom();
    dut.rom[0] = enc(1, 0, 7, 0, 0, 0, 0, 'h11);
    dut.rom[1] = enc(1, 1, 7, 0, 0, 0, 0, 'h22);
    dut.rom[2] = enc(1, 2, 7, 0, 0, 0, 0, 'h33);
    dut.rom[3] = enc(1, 3, 7, 0, 0, 0, 0, 'h44);
    dut.rom[4] = enc(1, 4, 7, 0, 0, 0, 0, 'h55);
    dut.rom[5] = enc(1, 5, 7, 0, 0, 0, 0, 'h66);
    dut.rom[6] = enc(12, 8, 7, 0, 0, 1, 0, 'h80);
    dut.rom[7] = enc(1, 6, 7, 0, 0, 0, 0, 'h77);
    dut.ram[16'h6655] = 8'h00;
    apply_reset();
    repeat (7) tick();
    check("mid_pc", {16'h0, dut.pc}, 32'h7);
    check("mid_regs", {dut.reg_a, dut.reg_b, dut.reg_c, dut.reg_d}, 32'h11223344);
    check("mid_mar", {16'h0, dut.marhi, dut.marlo}, 32'h6655);
    check_flags("mid_flags", 4'b1100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_pc", {16'h0, dut.pc}, 32'h0);
    check("rst2_regs", {dut.reg_a, dut.reg_b, dut.reg_c, dut.reg_d}, 32'h0);
    check("rst2_mar", {16'h0, dut.marhi, dut.marlo}, 32'h0);
    check_flags("rst2_flags", 4'b0000);
    check("rst2_ram", {24'h0, dut.ram[16'h6655]}, 32'h0);

    // Conditional jumps on Z and C
    clear_rom();
    dut.rom[0]    = enc(1, 0, 7, 0, 0, 0, 0, 'hFF);
    dut.rom[1]    = enc(1, 1, 7, 0, 0, 0, 0, 'h01);
    dut.rom[2]    = enc(3, 0, 0, 1, 0, 1, 0, 0);
    dut.rom[3]    = enc(0, 7, 0, 0, 2, 0, 'h0080, 0);
    dut.rom[4]    = enc(0, 7, 0, 0, 1, 0, 'h0040, 0);
    dut.rom['h40] = enc(0, 7, 0, 0, 4, 0, 'h0100, 0);
    dut.rom['h41] = enc(0, 7, 0, 0, 3, 0, 'h0200, 0);
    apply_reset();
    repeat (3) tick();
    check("jz_a", {24'h0, dut.reg_a}, 32'h0);
    check_flags("jz_flags", 4'b1100);
    tick();
    check("jnz_fall_pc", {16'h0, dut.pc}, 32'h4);
    tick();
    check("jz_taken_pc", {16'h0, dut.pc}, 32'h40);
    tick();
    check("jnc_fall_pc", {16'h0, dut.pc}, 32'h41);
    tick();
    check("jc_taken_pc", {16'h0, dut.pc}, 32'h200);

    // PC wrap on a sequential NOOP at 0xFFFF
    clear_rom();
    dut.rom[0]      = enc(0, 7, 0, 0, 0, 0, 'hFFFE, 0);
    dut.rom['hFFFF] = enc(0, 8, 0, 0, 0, 0, 0, 0);
    apply_reset();
    tick();
    check("wrap_pc0", {16'h0, dut.pc}, 32'hFFFE);
    tick();
    check("wrap_pc1", {16'h0, dut.pc}, 32'hFFFF);
    tick();
    check("wrap_pc2", {16'h0, dut.pc}, 32'h0);

    // RAM access, read-old/write-new, then NEVER and NOOP-target instructions
    clear_rom();
    dut.ram[16'h1234] = 8'h00;
    dut.ram[16'h12A6] = 8'h00;
    dut.rom[0] = enc(1, 5, 7, 0, 0, 0, 0, 'h12);
    dut.rom[1] = enc(1, 4, 7, 0, 0, 0, 0, 'h34);
    dut.rom[2] = enc(1, 6, 7, 0, 0, 0, 0, 'hA5);
    dut.rom[3] = enc(1, 0, 6, 0, 0, 0, 0, 0);
    dut.rom[4] = enc(14, 6, 6, 0, 0, 0, 0, 0);
    dut.rom[5] = enc(1, 1, 6, 0, 0, 0, 0, 0);
    dut.rom[6] = enc(1, 4, 6, 0, 0, 0, 0, 0);
    dut.rom[7] = enc(0, 0, 0, 0, 7, 1, 0, 0);
    dut.rom[8] = enc(1, 9, 7, 0, 0, 0, 0, 'h55);
    dut.rom[9] = enc(1, 6, 7, 0, 7, 0, 0, 'h99);
    apply_reset();
    repeat (4) tick();
    check("ram_load_a", {24'h0, dut.reg_a}, 32'hA5);
    check("ram_cell", {24'h0, dut.ram[16'h1234]}, 32'hA5);
    repeat (3) tick();
    check("ram_rmw", {24'h0, dut.ram[16'h1234]}, 32'hA6);
    check("ram_load_b", {24'h0, dut.reg_b}, 32'hA6);
    check("mar_from_ram", {16'h0, dut.marhi, dut.marlo}, 32'h12A6);
    repeat (3) tick();
    check("never_pc", {16'h0, dut.pc}, 32'hA);
    check("never_regs", {dut.reg_a, dut.reg_b, dut.marhi, dut.marlo}, 32'hA5A612A6);
    check_flags("never_flags", 4'b0000);
    check("never_ram", {24'h0, dut.ram[16'h12A6]}, 32'h0);
    check("never_ram_old", {24'h0, dut.ram[16'h1234]}, 32'hA6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
